store_narrow_serializer: RTL and testbench
==========================================

// Module: store_narrow_serializer
// PURPOSE
//  Store-path counterpart of the load-side immediate/data sign extender: narrows a 32-bit register value
//  to byte/half/word and serializes it as little-endian byte writes onto an 8-bit data-memory port.
//  Sits between the datapath store stage and byte-wide data memory.
//  Flags values whose high bits are not a pure sign extension of the narrowed value (lossy narrowing).
// PARAMETERS
//  AW  32  address width (req_addr, mem_addr)
// PORTS
//  clk         in   1   clock, rising edge
//  reset       in   1   asynchronous, active-high reset
//  req_valid   in   1   store request present
//  req_ready   out  1   block can accept request (IDLE only)
//  req_addr    in   AW  byte address of store
//  req_data    in   32  register value to store
//  req_size    in   2   00 byte, 01 half, 10 word, 11 reserved
//  mem_we      out  1   byte write strobe
//  mem_addr    out  AW  byte address of current write
//  mem_wdata   out  8   byte being written
//  mem_ack     in   1   memory accepts the byte this cycle (when mem_we=1)
//  done        out  1   one-cycle pulse: transaction finished
//  trunc_ovf   out  1   valid with done: narrowing was lossy
//  err         out  1   valid with done: misaligned or reserved size, nothing written
// BEHAVIOUR
//  - Reset (async): state IDLE; req_ready=1, mem_we=0, mem_addr=0, mem_wdata=0, done=0, trunc_ovf=0, err=0, byte index=0.
//  - FSM IDLE -> SEND -> DONE -> IDLE; IDLE -> DONE directly on error.
//  - IDLE: req_ready=1. On req_valid&req_ready at edge: latch addr/data/size, N=1/2/4 bytes.
//    Error if size=11, or size=01 and addr[0]!=0, or size=10 and addr[1:0]!=0 -> DONE with err=1, no mem_we.
//  - trunc_ovf computed at accept: byte: data[31:7] not all equal; half: data[31:15] not all equal; word: 0.
//  - SEND: mem_we=1, mem_addr=latched addr+k, mem_wdata=narrowed byte k (k=0 first, little-endian).
//    Outputs held stable until mem_ack=1; on ack k increments; ack on byte N-1 -> DONE.
//  - DONE: exactly one cycle, done=1, trunc_ovf/err valid; then IDLE. trunc_ovf/err=0 outside DONE.
//  - req_ready=0 in SEND and DONE; req_valid ignored there (no queuing).
//  - Latency with mem_ack tied 1, accept at edge T: bytes in cycles T+1..T+N, done at T+N+1,
//    req_ready at T+N+2. Error case: done at T+1.
//  - mem_ack while mem_we=0 ignored. Address increment wraps modulo 2^AW.
//  - Reset mid-transaction: immediate abort to IDLE, mem_we drops, no done; bytes already written stay.
// CONFIGURATION
//  SATURATE_STORE_EN defined: when trunc_ovf=1, written value is saturated per sign req_data[31]:
//    byte 0x7F / 0x80, half 0x7FFF / 0x8000. trunc_ovf still reported.
//  Not defined: plain truncation to low N bytes; trunc_ovf still reported.
// TESTING
//  1. word, addr 0x100, data 0x11223344, ack=1 -> 44@100,33@101,22@102,11@103, done T+5, ovf=0, err=0.
//  2. byte, data 0xFFFFFF80 -> 0x80 written, ovf=0; data 0x00000180 -> ovf=1, writes 0x80 (0x7F w/ SATURATE_STORE_EN).
//  3. half, addr 0x101 -> no mem_we, done at T+1 with err=1; size=11 at addr 0x0 -> same.
//  4. half, addr 0x200, data 0xFFFF8001, ack low 3 cycles per byte -> addr/wdata/we held stable, 01@200, 80@201, single done.
//  5. word store, reset asserted after 2nd ack -> mem_we=0 immediately, no done, req_ready=1 after release.
//  6. req_valid held high over two requests -> second accepted only in cycle after DONE; no byte lost or duplicated.

Source files
------------

// File: rtl/store_narrow_serializer.sv
// Narrows a 32-bit store value to byte/half/word and writes it little-endian, one byte per beat.
// Optional build macro SATURATE_STORE_EN: on a lossy narrowing, write the saturated value instead of the truncated one.
module store_narrow_serializer #(
   parameter int AW = 32
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic [AW-1:0] req_addr,
   input  logic [31:0]   req_data,
   input  logic [1:0]    req_size,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [7:0]    mem_wdata,
   input  logic          mem_ack,
   output logic          done,
   output logic          trunc_ovf,
   output logic          err,
   output logic [1:0]    dbg_state
);

   // Handshakes: a request moves on a rising edge where req_valid && req_ready;
   // a byte moves on a rising edge where mem_we && mem_ack. Outputs hold otherwise.

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t        state, state_nx;
   logic [AW-1:0] addr_q;
   logic [31:0]   wdata_q;
   logic [1:0]    k_q;
   logic [1:0]    last_q;
   logic          ovf_q;
   logic          err_q;

   logic          accept;
   logic          err_c;
   logic          ovf_c;
   logic [1:0]    last_c;
   logic [31:0]   narrow_c;

   assign accept = req_valid && (state == IDLE);

   // Classify the incoming request: alignment, size and lossiness.
   always_comb begin
      err_c    = 1'b0;
      ovf_c    = 1'b0;
      last_c   = 2'd0;
      narrow_c = req_data;
      case (req_size)
         2'b00: begin
            last_c = 2'd0;
            ovf_c  = !((&req_data[31:7]) || (~|req_data[31:7]));
         end
         2'b01: begin
            last_c = 2'd1;
            err_c  = req_addr[0];
            ovf_c  = !((&req_data[31:15]) || (~|req_data[31:15]));
         end
         2'b10: begin
            last_c = 2'd3;
            err_c  = |req_addr[1:0];
         end
         default: begin
            err_c = 1'b1;
         end
      endcase
`ifdef SATURATE_STORE_EN
      if (ovf_c) begin
         if (req_size == 2'b00)
            narrow_c = {24'd0, req_data[31] ? 8'h80 : 8'h7F};
         else
            narrow_c = {16'd0, req_data[31] ? 16'h8000 : 16'h7FFF};
      end
`else
      // Plain truncation: the low N bytes of req_data are what gets written.
      narrow_c = req_data;
`endif
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state <= IDLE;
      else
         state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE: begin
            if (accept)
               state_nx = err_c ? DONE : SEND;
         end
         SEND: begin
            if (mem_ack && (k_q == last_q))
               state_nx = DONE;
         end
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         addr_q  <= '0;
         wdata_q <= '0;
         k_q     <= 2'd0;
         last_q  <= 2'd0;
         ovf_q   <= 1'b0;
         err_q   <= 1'b0;
      end else if (accept) begin
         addr_q  <= req_addr;
         wdata_q <= narrow_c;
         k_q     <= 2'd0;
         last_q  <= last_c;
         ovf_q   <= ovf_c && !err_c;
         err_q   <= err_c;
      end else if ((state == SEND) && mem_ack) begin
         k_q <= k_q + 2'd1;
      end
   end

   // Outputs decode straight from state so a reset drops them immediately.
   always_comb begin
      req_ready = (state == IDLE);
      mem_we    = (state == SEND);
      mem_addr  = '0;
      mem_wdata = 8'h00;
      if (state == SEND) begin
         mem_addr  = addr_q + AW'(k_q);
         mem_wdata = wdata_q[8*k_q +: 8];
      end
      done      = (state == DONE);
      trunc_ovf = (state == DONE) && ovf_q;
      err       = (state == DONE) && err_q;
      dbg_state = state;
   end

endmodule

// File: tb/tb_store_narrow_serializer.sv
// Directed bench for store_narrow_serializer: per-cycle checks plus a byte-write scoreboard.
module tb_store_narrow_serializer;

   localparam int AW = 32;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic [AW-1:0] req_addr = '0;
   logic [31:0]   req_data = '0;
   logic [1:0]    req_size = 2'b00;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [7:0]    mem_wdata;
   logic          mem_ack = 1'b1;
   logic          done;
   logic          trunc_ovf;
   logic          err;
   logic [1:0]    dbg_state;

   int n_chk  = 0;
   int n_pass = 0;
   int done_cnt = 0;
   logic [AW+7:0] exp_q[$];

   store_narrow_serializer #(.AW(AW)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_addr(req_addr), .req_data(req_data), .req_size(req_size),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
      .done(done), .trunc_ovf(trunc_ovf), .err(err), .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   // Scoreboard: every accepted byte write must match the head of exp_q.
   always @(negedge clk) begin
      if (done === 1'b1) done_cnt++;
      if (mem_we === 1'b1 && mem_ack === 1'b1) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_write", {mem_addr[23:0], mem_wdata}, 32'hFFFFFFFF);
         end else begin
            logic [AW+7:0] e;
            e = exp_q.pop_front();
            chk("write_addr", mem_addr, e[AW+7:8]);
            chk("write_data", {24'd0, mem_wdata}, {24'd0, e[7:0]});
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_byte(input logic [AW-1:0] a, input logic [7:0] d);
      exp_q.push_back({a, d});
   endtask

   task automatic run_store(input string tag, input logic [AW-1:0] a, input logic [31:0] d,
                            input logic [1:0] s, input int exp_lat,
                            input logic exp_ovf, input logic exp_err);
      int lat;
      req_addr = a; req_data = d; req_size = s; req_valid = 1'b1;
      chk({tag, "_ready"}, req_ready, 1);
      step();
      req_valid = 1'b0;
      lat = 1;
      while (done !== 1'b1 && lat < 20) begin
         step();
         lat++;
      end
      chk({tag, "_latency"}, lat, exp_lat);
      chk({tag, "_ovf"}, trunc_ovf, exp_ovf);
      chk({tag, "_err"}, err, exp_err);
      step();
      chk({tag, "_done_low"}, done, 0);
      chk({tag, "_ready_after"}, req_ready, 1);
   endtask

   initial begin
      // Reset values
      #2;
      chk("rst_ready", req_ready, 1);
      chk("rst_we", mem_we, 0);
      chk("rst_addr", mem_addr, 0);
      chk("rst_wdata", mem_wdata, 0);
      chk("rst_done", done, 0);
      chk("rst_ovf", trunc_ovf, 0);
      chk("rst_err", err, 0);
      chk("rst_state", dbg_state, 0);
      step();
      reset = 1'b0;
      step();

      // 1: word store, cycle-exact
      expect_byte(32'h100, 8'h44); expect_byte(32'h101, 8'h33);
      expect_byte(32'h102, 8'h22); expect_byte(32'h103, 8'h11);
      req_addr = 32'h100; req_data = 32'h11223344; req_size = 2'b10; req_valid = 1'b1;
      step();
      req_valid = 1'b0;
      chk("w_t1_we", mem_we, 1);
      chk("w_t1_addr", mem_addr, 32'h100);
      chk("w_t1_data", mem_wdata, 8'h44);
      chk("w_t1_ready", req_ready, 0);
      step();
      chk("w_t2_addr", mem_addr, 32'h101);
      chk("w_t2_data", mem_wdata, 8'h33);
      step();
      chk("w_t3_data", mem_wdata, 8'h22);
      step();
      chk("w_t4_addr", mem_addr, 32'h103);
      chk("w_t4_data", mem_wdata, 8'h11);
      step();
      chk("w_t5_done", done, 1);
      chk("w_t5_we", mem_we, 0);
      chk("w_t5_ovf", trunc_ovf, 0);
      chk("w_t5_err", err, 0);
      step();
      chk("w_t6_done", done, 0);
      chk("w_t6_ready", req_ready, 1);

      // 2: byte stores, pure sign extension vs lossy
      expect_byte(32'h10, 8'h80);
      run_store("b_sext", 32'h10, 32'hFFFFFF80, 2'b00, 2, 1'b0, 1'b0);
`ifdef SATURATE_STORE_EN
      expect_byte(32'h11, 8'h7F);
`else
      expect_byte(32'h11, 8'h80);
`endif
      run_store("b_lossy", 32'h11, 32'h00000180, 2'b00, 2, 1'b1, 1'b0);
`ifdef SATURATE_STORE_EN
      expect_byte(32'h20, 8'hFF); expect_byte(32'h21, 8'h7F);
`else
      expect_byte(32'h20, 8'h45); expect_byte(32'h21, 8'h23);
`endif
      run_store("h_lossy", 32'h20, 32'h00012345, 2'b01, 3, 1'b1, 1'b0);

      // 3: misaligned half and reserved size -> error, no writes
      run_store("h_misal", 32'h101, 32'h12345678, 2'b01, 1, 1'b0, 1'b1);
      run_store("rsvd", 32'h0, 32'h12345678, 2'b11, 1, 1'b0, 1'b1);

      // 4: half store with memory stalls
      expect_byte(32'h200, 8'h01); expect_byte(32'h201, 8'h80);
      mem_ack = 1'b0;
      req_addr = 32'h200; req_data = 32'hFFFF8001; req_size = 2'b01; req_valid = 1'b1;
      step();
      req_valid = 1'b0;
      for (int b = 0; b < 2; b++) begin
         for (int c = 0; c < 4; c++) begin
            chk("stall_we", mem_we, 1);
            chk("stall_addr", mem_addr, 32'h200 + b);
            chk("stall_data", mem_wdata, (b == 0) ? 8'h01 : 8'h80);
            chk("stall_done", done, 0);
            if (c == 3) mem_ack = 1'b1;
            step();
            mem_ack = 1'b0;
         end
      end
      chk("stall_end_done", done, 1);
      chk("stall_end_ovf", trunc_ovf, 0);
      mem_ack = 1'b1;
      step();
      chk("stall_single_done", done, 0);

      // 5: reset after second ack of a word store
      expect_byte(32'h300, 8'hD4); expect_byte(32'h301, 8'hC3);
      req_addr = 32'h300; req_data = 32'hA1B2C3D4; req_size = 2'b10; req_valid = 1'b1;
      step();
      req_valid = 1'b0;
      step();
      step();
      chk("abort_pre_addr", mem_addr, 32'h302);
      reset = 1'b1;
      #1;
      chk("abort_we", mem_we, 0);
      chk("abort_done", done, 0);
      step();
      reset = 1'b0;
      step();
      chk("abort_ready", req_ready, 1);
      chk("abort_no_done", done, 0);

      // 6: req_valid held high across two requests
      expect_byte(32'h400, 8'h55); expect_byte(32'h401, 8'h66);
      req_addr = 32'h400; req_data = 32'h00000055; req_size = 2'b00; req_valid = 1'b1;
      step();
      req_addr = 32'h401; req_data = 32'h00000066;
      chk("hold_t1_ready", req_ready, 0);
      chk("hold_t1_data", mem_wdata, 8'h55);
      step();
      chk("hold_t2_done", done, 1);
      chk("hold_t2_ready", req_ready, 0);
      step();
      chk("hold_t3_ready", req_ready, 1);
      chk("hold_t3_we", mem_we, 0);
      step();
      req_valid = 1'b0;
      chk("hold_t4_addr", mem_addr, 32'h401);
      chk("hold_t4_data", mem_wdata, 8'h66);
      step();
      chk("hold_t5_done", done, 1);
      step();
      step();

      chk("sb_empty", exp_q.size(), 0);
      chk("done_total", done_cnt, 9);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
